// File: rtl/bvm_pkg.sv
// Shared types and defaults for the multi-channel beverage dispenser.
// Optional cancel input is enabled with the BVM_CANCEL_EN macro.
package bvm_pkg;

    typedef enum logic [1:0] {
        BVM_IDLE     = 2'd0,
        BVM_DISPENSE = 2'd1,
        BVM_DONE     = 2'd2
    } bvm_state_t;

    localparam int unsigned BVM_NUM_BEV_DEF         = 4;
    localparam int unsigned BVM_DISPENSE_CYCLES_DEF = 10;
    localparam int unsigned BVM_STOCK_W_DEF         = 4;
    localparam int unsigned BVM_STOCK_INIT_DEF      = 8;

    // Counter holds 0..cycles-1; never narrower than one bit.
    function automatic int unsigned bvm_cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/bvm_multi_dispenser_stock_counter.sv
// Per-channel stock counter: reload on refill, decrement on accepted dispense.
module bvm_stock_counter #(
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 8
) (
    input  logic               BVMclk,
    input  logic               BVMrst_n,
    input  logic               load,
    input  logic               dec,
    output logic [STOCK_W-1:0] count,
    output logic               empty
);

    always_ff @(posedge BVMclk) begin
        if (!BVMrst_n) begin
            count <= STOCK_W'(STOCK_INIT);
        end else if (load && dec) begin
            // Refill and dispense on the same edge: the dispense consumes from the fresh load.
            count <= STOCK_W'(STOCK_INIT - 1);
        end else if (load) begin
            count <= STOCK_W'(STOCK_INIT);
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    always_comb begin
        empty = (count == '0);
    end

endmodule

// File: rtl/bvm_multi_dispenser.sv
// Beverage vending controller: arbitrates one request at a time, tracks stock, times dispense.
// Define BVM_CANCEL_EN to add the BVMcancel input that ends a dispense early.
module bvm_multi_dispenser
    import bvm_pkg::*;
#(
    parameter int unsigned NUM_BEV         = BVM_NUM_BEV_DEF,
    parameter int unsigned DISPENSE_CYCLES = BVM_DISPENSE_CYCLES_DEF,
    parameter int unsigned STOCK_W         = BVM_STOCK_W_DEF,
    parameter int unsigned STOCK_INIT      = BVM_STOCK_INIT_DEF,
    parameter int unsigned SEL_W           = $clog2(NUM_BEV)
) (
    input  logic               BVMclk,
    input  logic               BVMrst_n,
    input  logic               BVMd,
    input  logic [SEL_W-1:0]   BVMin,
    input  logic               BVMrefill,
    input  logic [SEL_W-1:0]   BVMrefill_sel,
`ifdef BVM_CANCEL_EN
    input  logic               BVMcancel,
`endif
    output logic               BVMvalid,
    output logic [SEL_W-1:0]   BVMactive,
    output logic               BVMdone,
    output logic               BVMreject,
    output logic [NUM_BEV-1:0] BVMempty
);

    localparam int unsigned CNT_W = bvm_cnt_width(DISPENSE_CYCLES);

    bvm_state_t                      state_q, state_d;
    logic [CNT_W-1:0]                cnt_q;
    logic [SEL_W-1:0]                active_q;
    logic                            reject_q;
    logic [NUM_BEV-1:0][STOCK_W-1:0] stock;
    logic [NUM_BEV-1:0]              empty, load, dec;
    logic                            req_ok, accept, reject_d, last_cycle, cancel;

`ifdef BVM_CANCEL_EN
    assign cancel = BVMcancel;
`else
    assign cancel = 1'b0;
`endif

    // Out-of-range selects match no channel, so they fall through to a reject.
    always_comb begin
        req_ok = 1'b0;
        for (int unsigned i = 0; i < NUM_BEV; i++) begin
            if (BVMin == SEL_W'(i) && !empty[i]) req_ok = 1'b1;
        end
    end

    always_comb begin
        accept     = (state_q == BVM_IDLE) && BVMd && req_ok;
        reject_d   = (state_q == BVM_IDLE) && BVMd && !req_ok;
        last_cycle = (cnt_q == CNT_W'(DISPENSE_CYCLES - 1));
    end

    always_ff @(posedge BVMclk) begin
        if (!BVMrst_n) begin
            state_q  <= BVM_IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            reject_q <= reject_d;
            if (state_q == BVM_DISPENSE && state_d == BVM_DISPENSE) cnt_q <= cnt_q + 1'b1;
            else                                                    cnt_q <= '0;
            if (accept)                     active_q <= BVMin;
            else if (state_q == BVM_DONE)   active_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BVM_IDLE:     if (accept) state_d = BVM_DISPENSE;
            BVM_DISPENSE: if (last_cycle || cancel) state_d = BVM_DONE;
            BVM_DONE:     state_d = BVM_IDLE;
            default:      state_d = BVM_IDLE;
        endcase
    end

    always_comb begin
        BVMvalid  = (state_q == BVM_DISPENSE);
        BVMdone   = (state_q == BVM_DONE);
        BVMactive = active_q;
        BVMreject = reject_q;
        BVMempty  = empty;
    end

    for (genvar g = 0; g < NUM_BEV; g++) begin : g_stock
        assign load[g] = BVMrefill && (BVMrefill_sel == SEL_W'(g));
        assign dec[g]  = accept && (BVMin == SEL_W'(g));

        bvm_stock_counter #(
            .STOCK_W    (STOCK_W),
            .STOCK_INIT (STOCK_INIT)
        ) u_stock (
            .BVMclk   (BVMclk),
            .BVMrst_n (BVMrst_n),
            .load     (load[g]),
            .dec      (dec[g]),
            .count    (stock[g]),
            .empty    (empty[g])
        );
    end

endmodule

// File: tb/tb_bvm_multi_dispenser.sv
// Directed self-checking bench for bvm_multi_dispenser (3 channels, 10-cycle window, stock 8).
module tb_bvm_multi_dispenser;

    localparam int unsigned NB = 3;

    logic          BVMclk = 1'b0;
    logic          BVMrst_n = 1'b0;
    logic          BVMd = 1'b0;
    logic [1:0]    BVMin = '0;
    logic          BVMrefill = 1'b0;
    logic [1:0]    BVMrefill_sel = '0;
`ifdef BVM_CANCEL_EN
    logic          BVMcancel = 1'b0;
`endif
    logic          BVMvalid;
    logic [1:0]    BVMactive;
    logic          BVMdone;
    logic          BVMreject;
    logic [NB-1:0] BVMempty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 BVMclk = ~BVMclk;

    bvm_multi_dispenser #(
        .NUM_BEV         (NB),
        .DISPENSE_CYCLES (10),
        .STOCK_W         (4),
        .STOCK_INIT      (8)
    ) dut (
        .BVMclk        (BVMclk),
        .BVMrst_n      (BVMrst_n),
        .BVMd          (BVMd),
        .BVMin         (BVMin),
        .BVMrefill     (BVMrefill),
        .BVMrefill_sel (BVMrefill_sel),
`ifdef BVM_CANCEL_EN
        .BVMcancel     (BVMcancel),
`endif
        .BVMvalid      (BVMvalid),
        .BVMactive     (BVMactive),
        .BVMdone       (BVMdone),
        .BVMreject     (BVMreject),
        .BVMempty      (BVMempty)
    );

    task automatic tick();
        @(posedge BVMclk);
        #1;
    endtask

    task automatic test_reset();
        BVMrst_n = 1'b0;
        tick();
        tick();
        BVMrst_n = 1'b1;
        n_checks++; if (BVMvalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", BVMvalid); end
        n_checks++; if (BVMactive !== 2'd0) begin n_fail++; $display("FAIL reset_active: got %0d want 0", BVMactive); end
        n_checks++; if (BVMdone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", BVMdone); end
        n_checks++; if (BVMreject !== 1'b0) begin n_fail++; $display("FAIL reset_reject: got %b want 0", BVMreject); end
        n_checks++; if (BVMempty !== 3'b000) begin n_fail++; $display("FAIL reset_empty: got %b want 000", BVMempty); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (dut.stock[i] !== 4'd8) begin n_fail++; $display("FAIL reset_stock%0d: got %0d want 8", i, dut.stock[i]); end
        end
    endtask

    task automatic test_single();
        BVMd = 1'b1; BVMin = 2'd2;
        tick();
        BVMd = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (BVMvalid !== 1'b1 || BVMactive !== 2'd2 || BVMdone !== 1'b0)
                begin n_fail++; $display("FAIL single_win%0d: valid=%b active=%0d done=%b want 1/2/0", k, BVMvalid, BVMactive, BVMdone); end
            tick();
        end
        n_checks++; if (BVMvalid !== 1'b0 || BVMdone !== 1'b1 || BVMactive !== 2'd2)
            begin n_fail++; $display("FAIL single_done: valid=%b done=%b active=%0d want 0/1/2", BVMvalid, BVMdone, BVMactive); end
        tick();
        n_checks++; if (BVMdone !== 1'b0 || BVMactive !== 2'd0)
            begin n_fail++; $display("FAIL single_idle: done=%b active=%0d want 0/0", BVMdone, BVMactive); end
        n_checks++; if (dut.stock[2] !== 4'd7) begin n_fail++; $display("FAIL single_stock: got %0d want 7", dut.stock[2]); end
    endtask

    task automatic test_drain_refill();
        for (int r = 0; r < 8; r++) begin
            BVMd = 1'b1; BVMin = 2'd0;
            tick();
            BVMd = 1'b0;
            n_checks++; if (BVMvalid !== 1'b1 || BVMreject !== 1'b0)
                begin n_fail++; $display("FAIL drain_accept%0d: valid=%b reject=%b want 1/0", r, BVMvalid, BVMreject); end
            repeat (11) tick();
        end
        n_checks++; if (BVMempty !== 3'b001) begin n_fail++; $display("FAIL drain_empty: got %b want 001", BVMempty); end
        BVMd = 1'b1; BVMin = 2'd0;
        tick();
        BVMd = 1'b0;
        n_checks++; if (BVMreject !== 1'b1 || BVMvalid !== 1'b0)
            begin n_fail++; $display("FAIL drain_reject: reject=%b valid=%b want 1/0", BVMreject, BVMvalid); end
        tick();
        n_checks++; if (BVMreject !== 1'b0) begin n_fail++; $display("FAIL drain_reject_pulse: got %b want 0", BVMreject); end
        // Request and refill together on an empty channel: refused, stock reloaded.
        BVMd = 1'b1; BVMin = 2'd0; BVMrefill = 1'b1; BVMrefill_sel = 2'd0;
        tick();
        BVMd = 1'b0; BVMrefill = 1'b0;
        n_checks++; if (BVMreject !== 1'b1 || BVMvalid !== 1'b0)
            begin n_fail++; $display("FAIL refill_coll_reject: reject=%b valid=%b want 1/0", BVMreject, BVMvalid); end
        n_checks++; if (dut.stock[0] !== 4'd8 || BVMempty !== 3'b000)
            begin n_fail++; $display("FAIL refill_stock: stock=%0d empty=%b want 8/000", dut.stock[0], BVMempty); end
        tick();
    endtask

    task automatic test_invalid();
        BVMd = 1'b1; BVMin = 2'd3;
        tick();
        BVMd = 1'b0;
        n_checks++; if (BVMreject !== 1'b1 || BVMvalid !== 1'b0)
            begin n_fail++; $display("FAIL invalid_reject: reject=%b valid=%b want 1/0", BVMreject, BVMvalid); end
        n_checks++; if (dut.stock[0] !== 4'd8 || dut.stock[1] !== 4'd8 || dut.stock[2] !== 4'd7)
            begin n_fail++; $display("FAIL invalid_stock: %0d %0d %0d want 8 8 7", dut.stock[0], dut.stock[1], dut.stock[2]); end
        BVMrefill = 1'b1; BVMrefill_sel = 2'd3;
        tick();
        BVMrefill = 1'b0;
        n_checks++; if (BVMreject !== 1'b0 || dut.stock[2] !== 4'd7)
            begin n_fail++; $display("FAIL invalid_refill: reject=%b stock2=%0d want 0/7", BVMreject, dut.stock[2]); end
    endtask

    task automatic test_back_to_back();
        int p;
        BVMd = 1'b1;
        for (int t = 0; t < 36; t++) begin
            p = t % 12;
            BVMin = (p == 0) ? 2'd1 : ((p % 2 == 1) ? 2'd3 : 2'd0);
            tick();
            n_checks++; if (BVMreject !== 1'b0 || BVMvalid !== (p < 10) || BVMdone !== (p == 10))
                begin n_fail++; $display("FAIL b2b_t%0d: reject=%b valid=%b done=%b want 0/%b/%b", t, BVMreject, BVMvalid, BVMdone, p < 10, p == 10); end
        end
        BVMd = 1'b0;
        n_checks++; if (dut.stock[1] !== 4'd5 || dut.stock[0] !== 4'd8)
            begin n_fail++; $display("FAIL b2b_stock: s1=%0d s0=%0d want 5/8", dut.stock[1], dut.stock[0]); end
        // Refill landing on the same edge as an acceptance.
        BVMd = 1'b1; BVMin = 2'd2; BVMrefill = 1'b1; BVMrefill_sel = 2'd2;
        tick();
        BVMd = 1'b0; BVMrefill = 1'b0;
        n_checks++; if (BVMvalid !== 1'b1 || dut.stock[2] !== 4'd7)
            begin n_fail++; $display("FAIL refill_accept: valid=%b stock2=%0d want 1/7", BVMvalid, dut.stock[2]); end
        repeat (11) tick();
    endtask

    task automatic test_reset_mid();
        BVMd = 1'b1; BVMin = 2'd1;
        tick();
        BVMd = 1'b0;
        repeat (4) tick();
        n_checks++; if (BVMvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", BVMvalid); end
        BVMrst_n = 1'b0;
        tick();
        n_checks++; if (BVMvalid !== 1'b0 || BVMdone !== 1'b0 || BVMactive !== 2'd0)
            begin n_fail++; $display("FAIL mid_abort: valid=%b done=%b active=%0d want 0/0/0", BVMvalid, BVMdone, BVMactive); end
        n_checks++; if (dut.stock[0] !== 4'd8 || dut.stock[1] !== 4'd8 || dut.stock[2] !== 4'd8)
            begin n_fail++; $display("FAIL mid_stock: %0d %0d %0d want 8 8 8", dut.stock[0], dut.stock[1], dut.stock[2]); end
        BVMrst_n = 1'b1;
        tick();
        n_checks++; if (BVMdone !== 1'b0 || BVMvalid !== 1'b0)
            begin n_fail++; $display("FAIL mid_after: done=%b valid=%b want 0/0", BVMdone, BVMvalid); end
    endtask

`ifdef BVM_CANCEL_EN
    task automatic test_cancel();
        BVMd = 1'b1; BVMin = 2'd0;
        tick();
        BVMd = 1'b0;
        repeat (2) tick();
        BVMcancel = 1'b1;
        tick();
        BVMcancel = 1'b0;
        n_checks++; if (BVMvalid !== 1'b0 || BVMdone !== 1'b1 || dut.stock[0] !== 4'd7)
            begin n_fail++; $display("FAIL cancel: valid=%b done=%b stock0=%0d want 0/1/7", BVMvalid, BVMdone, dut.stock[0]); end
        tick();
        n_checks++; if (BVMdone !== 1'b0 || BVMactive !== 2'd0)
            begin n_fail++; $display("FAIL cancel_idle: done=%b active=%0d want 0/0", BVMdone, BVMactive); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_drain_refill();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
`ifdef BVM_CANCEL_EN
        test_cancel();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bvm_multi_dispenser.md
Name: bvm_multi_dispenser

Overview:
Parametrised next-generation beverage vending controller. Arbitrates one request at a time across NUM_BEV beverage channels, tracks per-channel stock, and holds a timed dispense window of DISPENSE_CYCLES. Requests for empty or invalid channels are rejected with a pulse instead of being silently dropped. Sits between the front-panel request logic and the per-channel valve drivers.

Parameters:
NUM_BEV, 4, number of beverage channels (>=2)
DISPENSE_CYCLES, 10, clock cycles BVMvalid stays high per dispense (>=1)
STOCK_W, 4, width of each per-channel stock counter
STOCK_INIT, 8, stock value loaded at reset and on refill (<=2**STOCK_W-1)
SEL_W, $clog2(NUM_BEV), channel select width (derived, not overridden)

Ports:
BVMclk  in  1  system clock, rising edge
BVMrst_n  in  1  synchronous active-low reset
BVMd  in  1  request strobe, sampled only in IDLE
BVMin  in  SEL_W  requested channel, sampled with BVMd
BVMrefill  in  1  refill strobe, accepted in any state
BVMrefill_sel  in  SEL_W  channel to refill
BVMvalid  out  1  dispense window active
BVMactive  out  SEL_W  channel being dispensed; 0 when idle
BVMdone  out  1  one-cycle pulse at end of dispense
BVMreject  out  1  one-cycle pulse: request refused
BVMempty  out  NUM_BEV  bit i set when stock[i]==0

Behaviour:
- One clock, BVMclk; reset is synchronous and active-low (BVMrst_n).
- Reset: state IDLE, BVMvalid=0, BVMactive=0, BVMdone=0, BVMreject=0, dispense counter=0, every stock=STOCK_INIT, BVMempty=0. Reset mid-dispense aborts immediately with no BVMdone.
- States: IDLE, DISPENSE, DONE.
- IDLE: on BVMd=1 at edge N, if BVMin<NUM_BEV and stock[BVMin]!=0 -> accept: stock decremented, BVMactive=BVMin, BVMvalid=1 from after edge N, state DISPENSE. Else BVMreject=1 for the cycle after N, stay IDLE.
- DISPENSE: counter increments each cycle; BVMvalid high for exactly DISPENSE_CYCLES cycles; on last cycle -> DONE. BVMd/BVMin ignored (no reject pulses while busy).
- DONE: single cycle; BVMvalid=0, BVMdone=1, BVMactive still holds channel; next state IDLE, BVMactive cleared. A request in DONE is ignored; earliest new acceptance is the first IDLE cycle.
- Back-to-back: request held high continuously gives one dispense per DISPENSE_CYCLES+2 cycles.
- Refill: BVMrefill=1 loads stock[BVMrefill_sel]=STOCK_INIT next edge; BVMrefill_sel>=NUM_BEV ignored. Does not disturb state machine.
- Simultaneous refill and acceptance on same channel: acceptance decision uses pre-refill stock; if accepted, resulting stock=STOCK_INIT-1; if stock was 0, request rejected and stock=STOCK_INIT.
- Stock never wraps: decrement only on accepted request (stock!=0 guaranteed).
- BVMempty is registered state of stock counters, combinationally decoded (no extra latency).

Optional Feature:
BVM_CANCEL_EN: adds input BVMcancel (1 bit). When defined, BVMcancel=1 during DISPENSE ends the window at the next edge: BVMvalid=0, state DONE, BVMdone pulses, stock stays decremented. Cancel in IDLE/DONE has no effect. Without the macro, port is absent and every dispense runs full DISPENSE_CYCLES.

Decomposition:
- Package bvm_pkg: state enum (BVM_IDLE, BVM_DISPENSE, BVM_DONE), default parameter constants, counter-width helper function for DISPENSE_CYCLES.
- Sub-module bvm_stock_counter: one per channel via generate; inputs load, dec; output count and empty flag; load and dec together -> STOCK_INIT-1.

Test Plan:
- Reset, then BVMd=1, BVMin=2 for one cycle -> BVMvalid high 10 cycles, BVMactive=2, BVMdone pulse on cycle 11, stock[2]=7.
- Nine requests to channel 0 with STOCK_INIT=8 -> eight dispenses, ninth gives BVMreject pulse, BVMempty[0]=1; BVMrefill to channel 0 -> BVMempty[0]=0, stock=8.
- NUM_BEV=3, request BVMin=3 -> BVMreject pulse, no BVMvalid, stocks unchanged.
- Requests toggling during DISPENSE and in DONE -> no reject, no second dispense until IDLE; held BVMd gives dispense every 12 cycles.
- BVMrst_n low at cycle 5 of dispense -> next edge BVMvalid=0, no BVMdone, all stocks back to 8.
- With BVM_CANCEL_EN: BVMcancel at cycle 3 of dispense -> BVMvalid low next edge, BVMdone pulses, stock stays decremented.
